conv_for_nmcu: RTL and testbench



---
 rtl/nmcu_pkg.sv | 14 +
 rtl/conv_for_nmcu_if.sv | 29 ++
 rtl/conv_mac.sv | 23 ++
 rtl/conv_for_nmcu.sv | 114 +++++++++++
 tb/tb_conv_for_nmcu.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nmcu_pkg.sv
// Shared NMCU definitions: convolution FSM states and default array dimensions.
package nmcu_pkg;

    localparam int MAX_INPUT_DIM  = 15;
    localparam int MAX_KERNEL_DIM = 7;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } conv_state_t;

endpackage

// File: rtl/conv_for_nmcu_if.sv
// Controller-facing bundle of the convolution PE: request/done handshake, sizes and data arrays.
interface conv_for_nmcu_if #(
    parameter int MAX_INPUT_DIM  = nmcu_pkg::MAX_INPUT_DIM,
    parameter int MAX_KERNEL_DIM = nmcu_pkg::MAX_KERNEL_DIM,
    parameter int DATABUS_WIDTH  = 32
);
    localparam int DW = $clog2(MAX_INPUT_DIM) + 1;
    localparam int KW = $clog2(MAX_KERNEL_DIM) + 1;

    logic                     start;
    logic                     done;
    logic [DW-1:0]            input_width;
    logic [DW-1:0]            input_height;
    logic [KW-1:0]            kernel_size;
    logic [DATABUS_WIDTH-1:0] local_kernel         [MAX_KERNEL_DIM][MAX_KERNEL_DIM];
    logic [DATABUS_WIDTH-1:0] local_activation_in  [MAX_INPUT_DIM][MAX_INPUT_DIM];
    logic [DATABUS_WIDTH-1:0] local_activation_out [MAX_INPUT_DIM][MAX_INPUT_DIM];

    modport master (
        output start, input_width, input_height, kernel_size, local_kernel, local_activation_in,
        input  done, local_activation_out
    );

    modport slave (
        input  start, input_width, input_height, kernel_size, local_kernel, local_activation_in,
        output done, local_activation_out
    );

endinterface

// File: rtl/conv_mac.sv
// Signed multiply-accumulate register; product and sum wrap modulo 2^DATABUS_WIDTH.
module conv_mac #(
    parameter int DATABUS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic [DATABUS_WIDTH-1:0] a,
    input  logic [DATABUS_WIDTH-1:0] b,
    output logic [DATABUS_WIDTH-1:0] acc
);

    // Only the low DATABUS_WIDTH bits of the product survive, so a same-width multiply suffices.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + DATABUS_WIDTH'($signed(a) * $signed(b));
        end
    end

endmodule

// File: rtl/conv_for_nmcu.sv
// Stride-1 valid 2-D convolution PE: one MAC per cycle, result written into a registered array.
module conv_for_nmcu #(
    parameter int MAX_INPUT_DIM  = nmcu_pkg::MAX_INPUT_DIM,
    parameter int MAX_KERNEL_DIM = nmcu_pkg::MAX_KERNEL_DIM,
    parameter int DATABUS_WIDTH  = 32
) (
    input logic            clk,
    input logic            rst,
    conv_for_nmcu_if.slave bus
);
    import nmcu_pkg::*;

    localparam int DW  = $clog2(MAX_INPUT_DIM) + 1;
    localparam int KW  = $clog2(MAX_KERNEL_DIM) + 1;
    localparam int AIW = $clog2(MAX_INPUT_DIM);
    localparam int KIW = $clog2(MAX_KERNEL_DIM);

    conv_state_t              state, state_next;
    logic [DW-1:0]            r, c, ohm1, owm1;
    logic [KW-1:0]            i, j, km1;
    logic                     degenerate;
    logic                     mac_clear;
    logic [AIW-1:0]           row_idx, col_idx;
    logic [DATABUS_WIDTH-1:0] act_val, ker_val, acc;

    always_comb begin
        degenerate = (bus.kernel_size == '0) || (bus.input_width == '0) || (bus.input_height == '0)
                  || (32'(bus.kernel_size) > 32'(bus.input_width))
                  || (32'(bus.kernel_size) > 32'(bus.input_height))
                  || (32'(bus.kernel_size) > 32'(MAX_KERNEL_DIM))
                  || (32'(bus.input_width) > 32'(MAX_INPUT_DIM))
                  || (32'(bus.input_height) > 32'(MAX_INPUT_DIM));
        row_idx   = AIW'(r + DW'(i));
        col_idx   = AIW'(c + DW'(j));
        act_val   = bus.local_activation_in[row_idx][col_idx];
        ker_val   = bus.local_kernel[KIW'(i)][KIW'(j)];
        mac_clear = (state == WRITE) || ((state == IDLE) && bus.start);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = degenerate ? DONE : MAC;
            MAC:     if ((i == km1) && (j == km1)) state_next = WRITE;
            WRITE:   state_next = ((r == ohm1) && (c == owm1)) ? DONE : MAC;
            DONE:    if (!bus.start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    conv_mac #(.DATABUS_WIDTH(DATABUS_WIDTH)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (state == MAC),
        .a     (act_val),
        .b     (ker_val),
        .acc   (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.done <= 1'b0;
            r        <= '0;
            c        <= '0;
            i        <= '0;
            j        <= '0;
            km1      <= '0;
            ohm1     <= '0;
            owm1     <= '0;
            for (int unsigned rr = 0; rr < MAX_INPUT_DIM; rr++)
                for (int unsigned cc = 0; cc < MAX_INPUT_DIM; cc++)
                    bus.local_activation_out[rr][cc] <= '0;
        end else begin
            state <= state_next;
            // done lags entry into DONE by one edge and falls on the edge that leaves DONE.
            bus.done <= (state == DONE) && (state_next == DONE);
            unique case (state)
                IDLE: if (bus.start) begin
                    r    <= '0;
                    c    <= '0;
                    i    <= '0;
                    j    <= '0;
                    km1  <= bus.kernel_size - KW'(1);
                    ohm1 <= bus.input_height - DW'(bus.kernel_size);
                    owm1 <= bus.input_width - DW'(bus.kernel_size);
                    for (int unsigned rr = 0; rr < MAX_INPUT_DIM; rr++)
                        for (int unsigned cc = 0; cc < MAX_INPUT_DIM; cc++)
                            bus.local_activation_out[rr][cc] <= '0;
                end
                MAC: begin
                    if (j == km1) begin
                        j <= '0;
                        i <= (i == km1) ? '0 : i + KW'(1);
                    end else begin
                        j <= j + KW'(1);
                    end
                end
                WRITE: begin
                    bus.local_activation_out[AIW'(r)][AIW'(c)] <= acc;
                    if (c == owm1) begin
                        c <= '0;
                        if (r != ohm1) r <= r + DW'(1);
                    end else begin
                        c <= c + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_for_nmcu.sv
// Bench for conv_for_nmcu: directed table, reset/restart sequences and random runs against a loop model.
module tb_conv_for_nmcu;

    localparam int MI  = 15;
    localparam int MK  = 7;
    localparam int DWB = 32;
    localparam int DW  = $clog2(MI) + 1;
    localparam int KW  = $clog2(MK) + 1;
    localparam int BUDGET = 5000;

    typedef struct {
        int          h;
        int          w;
        int          k;
        int          amode;   // 0 ramp, 1 ones, 2 random, 3 ramp with [0][0]=0x7FFFFFFF
        int          kmode;   // 0 constant kval, 1 [[1,0],[0,-1]], 2 random
        logic [31:0] kval;
        int          exp_edge;
        bit          chk00;
        logic [31:0] exp00;
    } vec_t;

    bit clk = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_out [MI][MI];
    vec_t tbl [11];

    conv_for_nmcu_if #(.MAX_INPUT_DIM(MI), .MAX_KERNEL_DIM(MK), .DATABUS_WIDTH(DWB)) bus ();

    conv_for_nmcu #(.MAX_INPUT_DIM(MI), .MAX_KERNEL_DIM(MK), .DATABUS_WIDTH(DWB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_degenerate(input int h, input int w, input int k);
        return (k < 1) || (w < 1) || (h < 1) || (k > w) || (k > h) || (k > MK) || (w > MI) || (h > MI);
    endfunction

    function automatic int edges_for(input int h, input int w, input int k);
        if (is_degenerate(h, w, k)) return 1;
        return 1 + (h - k + 1) * (w - k + 1) * (k * k + 1);
    endfunction

    // Direct evaluation of the convolution sum over the valid output window.
    task automatic model(input int h, input int w, input int k);
        logic [31:0] sum;
        for (int r = 0; r < MI; r++)
            for (int c = 0; c < MI; c++)
                exp_out[r][c] = '0;
        if (!is_degenerate(h, w, k)) begin
            for (int r = 0; r <= h - k; r++)
                for (int c = 0; c <= w - k; c++) begin
                    sum = '0;
                    for (int ii = 0; ii < k; ii++)
                        for (int jj = 0; jj < k; jj++)
                            sum = sum + bus.local_activation_in[r + ii][c + jj] * bus.local_kernel[ii][jj];
                    exp_out[r][c] = sum;
                end
        end
    endtask

    task automatic load(input vec_t v);
        logic [31:0] x;
        for (int r = 0; r < MI; r++)
            for (int c = 0; c < MI; c++) begin
                x = $urandom;
                if (r < v.h && c < v.w) begin
                    case (v.amode)
                        0, 3:    x = r * v.w + c + 1;
                        1:       x = 1;
                        default: ;
                    endcase
                    if (v.amode == 3 && r == 0 && c == 0) x = 32'h7FFF_FFFF;
                end
                bus.local_activation_in[r][c] = x;
            end
        for (int r = 0; r < MK; r++)
            for (int c = 0; c < MK; c++) begin
                x = $urandom;
                if (r < v.k && c < v.k) begin
                    case (v.kmode)
                        0:       x = v.kval;
                        1:       x = (r == 0 && c == 0) ? 32'd1 : (r == 1 && c == 1) ? 32'hFFFF_FFFF : 32'd0;
                        default: ;
                    endcase
                end
                bus.local_kernel[r][c] = x;
            end
        bus.input_height = DW'(v.h);
        bus.input_width  = DW'(v.w);
        bus.kernel_size  = KW'(v.k);
        model(v.h, v.w, v.k);
    endtask

    task automatic chk_array(input string tag);
        for (int r = 0; r < MI; r++)
            for (int c = 0; c < MI; c++)
                chk($sformatf("%s out[%0d][%0d]", tag, r, c), bus.local_activation_out[r][c], exp_out[r][c]);
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int n;
        bit got;
        @(negedge clk);
        load(v);
        bus.start = 1'b1;
        @(posedge clk);
        #1 chk({tag, " done low at edge 0"}, 32'(bus.done), 32'd0);
        n = 0;
        got = 1'b0;
        while (n < BUDGET && !got) begin
            @(posedge clk);
            #1;
            n++;
            got = bus.done;
        end
        chk({tag, " done edge"}, n, v.exp_edge);
        if (v.chk00) chk({tag, " out[0][0]"}, bus.local_activation_out[0][0], v.exp00);
        chk_array(tag);
        repeat (3) @(posedge clk);
        #1 chk({tag, " done held"}, 32'(bus.done), 32'd1);
        chk({tag, " out held"}, bus.local_activation_out[0][0], exp_out[0][0]);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1 chk({tag, " done drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{h: 3,  w: 3,  k: 1, amode: 0, kmode: 0, kval: 32'd2, exp_edge: 19,   chk00: 1, exp00: 32'd2};
        tbl[1]  = '{h: 4,  w: 4,  k: 3, amode: 1, kmode: 0, kval: 32'd1, exp_edge: 41,   chk00: 1, exp00: 32'd9};
        tbl[2]  = '{h: 3,  w: 3,  k: 2, amode: 0, kmode: 1, kval: 32'd0, exp_edge: 21,   chk00: 1, exp00: 32'hFFFF_FFFC};
        tbl[3]  = '{h: 3,  w: 3,  k: 5, amode: 0, kmode: 0, kval: 32'd1, exp_edge: 1,    chk00: 1, exp00: 32'd0};
        tbl[4]  = '{h: 3,  w: 3,  k: 0, amode: 0, kmode: 0, kval: 32'd1, exp_edge: 1,    chk00: 1, exp00: 32'd0};
        tbl[5]  = '{h: 2,  w: 2,  k: 1, amode: 3, kmode: 0, kval: 32'd2, exp_edge: 9,    chk00: 1, exp00: 32'hFFFF_FFFE};
        tbl[6]  = '{h: 5,  w: 3,  k: 2, amode: 1, kmode: 0, kval: 32'd3, exp_edge: 41,   chk00: 1, exp00: 32'd12};
        tbl[7]  = '{h: 15, w: 15, k: 7, amode: 1, kmode: 0, kval: 32'd1, exp_edge: 4051, chk00: 1, exp00: 32'd49};
        tbl[8]  = '{h: 16, w: 15, k: 3, amode: 1, kmode: 0, kval: 32'd1, exp_edge: 1,    chk00: 1, exp00: 32'd0};
        tbl[9]  = '{h: 15, w: 15, k: 8, amode: 1, kmode: 0, kval: 32'd1, exp_edge: 1,    chk00: 1, exp00: 32'd0};
        tbl[10] = '{h: 3,  w: 4,  k: 4, amode: 1, kmode: 0, kval: 32'd1, exp_edge: 1,    chk00: 1, exp00: 32'd0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.input_width = '0;
        bus.input_height = '0;
        bus.kernel_size = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset done", 32'(bus.done), 32'd0);
        for (int r = 0; r < MI; r++)
            for (int c = 0; c < MI; c++)
                exp_out[r][c] = '0;
        chk_array("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 11; t++)
            run_case(tbl[t], $sformatf("vec%0d", t));

        // Reset in the middle of a run, then a clean rerun of the same job.
        @(negedge clk);
        load(tbl[1]);
        bus.start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1 chk("midrun reset done", 32'(bus.done), 32'd0);
        for (int r = 0; r < MI; r++)
            for (int c = 0; c < MI; c++)
                exp_out[r][c] = '0;
        chk_array("midrun reset");
        @(negedge clk);
        rst = 1'b0;
        run_case(tbl[1], "rerun");

        for (int t = 0; t < 6; t++) begin
            v.h = $urandom_range(1, 16);
            v.w = $urandom_range(1, 16);
            v.k = $urandom_range(0, 8);
            v.amode = 2;
            v.kmode = 2;
            v.kval = '0;
            v.exp_edge = edges_for(v.h, v.w, v.k);
            v.chk00 = 1'b0;
            v.exp00 = '0;
            run_case(v, $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
